// File: rtl/reg_file_pkg.sv
// Shared definitions for the register bank: function-select encodings and the per-register
// next-value function used by both the cells and the read bypass.
package reg_file_pkg;

  // Widest register supported by next_value; WIDTH must not exceed this.
  localparam int unsigned MaxWidth = 64;

  typedef logic [MaxWidth-1:0] word_t;

  typedef enum logic [2:0] {
    FS_DEC    = 3'b000,
    FS_INC    = 3'b001,
    FS_LOAD   = 3'b010,
    FS_CLR    = 3'b011,
    FS_LDLO_Z = 3'b100,
    FS_LDLO_K = 3'b101,
    FS_SHL    = 3'b110,
    FS_ASR    = 3'b111
  } fun_sel_e;

  // Operands are zero-extended to MaxWidth; the result is masked back to 'width' bits.
  function automatic word_t next_value(input word_t       r,
                                       input word_t       i,
                                       input logic [2:0]  fun_sel,
                                       input int unsigned width);
    word_t one;
    word_t mask;
    word_t lo_mask;
    word_t res;
    one     = word_t'(1);
    mask    = (width >= MaxWidth) ? '1 : ((one << width) - one);
    lo_mask = (one << (width / 2)) - one;
    case (fun_sel_e'(fun_sel))
      FS_DEC:    res = (r - one) & mask;
      FS_INC:    res = (r + one) & mask;
      FS_LOAD:   res = i & mask;
      FS_CLR:    res = '0;
      FS_LDLO_Z: res = i & lo_mask;
      FS_LDLO_K: res = (r & mask & ~lo_mask) | (i & lo_mask);
      FS_SHL:    res = (r << 1) & mask;
      FS_ASR:    res = (r >> 1) | (r[width-1] ? (one << (width - 1)) : '0);
      default:   res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One register of the bank with its function unit and single-level shadow copy.
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic             Save,
  input  logic             Restore,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Next,
  output logic             Zero
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] op_res;

  assign op_res = WIDTH'(next_value(word_t'(q_q), word_t'(I), FunSel, WIDTH));

  // Priority: Reset, then Restore (drops writes and any Save), then Save alongside writes.
  always_comb begin
    q_d      = q_q;
    shadow_d = shadow_q;
    if (Reset) begin
      q_d      = '0;
      shadow_d = '0;
    end else if (Restore) begin
      q_d = shadow_q;
    end else begin
      if (Save) shadow_d = q_q;
      if (E)    q_d      = op_res;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q      <= '0;
      shadow_q <= '0;
    end else begin
      q_q      <= q_d;
      shadow_q <= shadow_d;
    end
  end

  assign Q    = q_q;
  assign Next = q_d;
  assign Zero = (q_q == '0);

endmodule

// File: rtl/param_register_file.sv
// Register bank: NUM_REGS function-unit registers with shadow save/restore and NUM_RD
// combinational read ports, optionally bypassing the value being written this cycle.
module param_register_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 0,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [WIDTH-1:0]          I,
  input  logic [NUM_REGS-1:0]       RegSel,
  input  logic [2:0]                FunSel,
  input  logic                      Save,
  input  logic                      Restore,
  input  logic [NUM_RD*SEL_W-1:0]   OutSel,
  output logic [NUM_RD*WIDTH-1:0]   Out,
  output logic [NUM_REGS-1:0]       Zero
);

  logic [WIDTH-1:0] q      [NUM_REGS];
  logic [WIDTH-1:0] next   [NUM_REGS];
  logic [WIDTH-1:0] rd_src [NUM_REGS];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
    reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (RegSel[k]),
      .FunSel (FunSel),
      .Save   (Save),
      .Restore(Restore),
      .I      (I),
      .Q      (q[k]),
      .Next   (next[k]),
      .Zero   (Zero[k])
    );

    // A cell's next state equals its stored value unless it is written, restored or reset.
    assign rd_src[k] = (BYPASS != 0) ? next[k] : q[k];
  end

  always_comb begin
    Out = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (32'(OutSel[p*SEL_W +: SEL_W]) < NUM_REGS) begin
        Out[p*WIDTH +: WIDTH] = rd_src[OutSel[p*SEL_W +: SEL_W]];
      end
    end
  end

endmodule
